// File: rtl/l1_cache_assoc_pkg.sv
// Shared types and constants for the set-associative L1 cache slice.
// Imported by the interface, the way storage and the cache controller.
package l1_cache_pkg;

    localparam int unsigned OFFSET_BITS = 2;
    localparam int unsigned DATA_WIDTH  = 32;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        READ_MISS,
        WRITE_THROUGH
    } cache_state_t;

endpackage

// File: rtl/l1_cache_assoc_if.sv
// CPU-side and memory-controller-side signals of the L1 cache.
// The cache uses the slave modport; the requester/controller side uses master.
interface l1_cache_assoc_if
    import l1_cache_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32
);

    logic                  request;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] input_data;
    logic                  should_write;
    logic                  flush;
    logic [DATA_WIDTH-1:0] output_data;
    logic                  hit;
    logic                  ready;

    logic                  mem_request;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_input_data;
    logic                  mem_should_write;
    logic [DATA_WIDTH-1:0] memory_controller_output_data;
    logic                  memory_controller_ready;

    logic [31:0]           hit_count;
    logic [31:0]           miss_count;

    modport master (
        output request, address, input_data, should_write, flush,
        output memory_controller_output_data, memory_controller_ready,
        input  output_data, hit, ready,
        input  mem_request, mem_address, mem_input_data, mem_should_write,
        input  hit_count, miss_count
    );

    modport slave (
        input  request, address, input_data, should_write, flush,
        input  memory_controller_output_data, memory_controller_ready,
        output output_data, hit, ready,
        output mem_request, mem_address, mem_input_data, mem_should_write,
        output hit_count, miss_count
    );

endinterface

// File: rtl/l1_cache_assoc_way.sv
// One cache way: per-set valid bits (reset/flushable) plus tag and data arrays.
// Read is combinational on the set index; the write port updates a whole line.
module l1_cache_way
    import l1_cache_pkg::*;
#(
    parameter int unsigned SETS       = 8,
    parameter int unsigned INDEX_BITS = 3,
    parameter int unsigned TAG_BITS   = 27
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic [INDEX_BITS-1:0] index,
    input  logic                  wr_en,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    output logic [TAG_BITS-1:0]   rd_tag,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [SETS-1:0]       valid;
    logic [TAG_BITS-1:0]   tags  [SETS];
    logic [DATA_WIDTH-1:0] lines [SETS];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid <= '0;
        end else if (flush) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[index] <= 1'b1;
        end
    end

    // Tag/data storage is deliberately left without reset; valid gates its use.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            tags[index]  <= wr_tag;
            lines[index] <= wr_data;
        end
    end

    assign rd_valid = valid[index];
    assign rd_tag   = tags[index];
    assign rd_data  = lines[index];

endmodule

// File: rtl/l1_cache_assoc.sv
// Write-through, write-allocate L1 cache, 1- or 2-way set associative, one word per line.
// Two-process FSM sequences lookup, read-miss fill and write-through against a memory controller.
module l1_cache_assoc
    import l1_cache_pkg::*;
#(
    parameter int unsigned CACHE_LINES = 16,
    parameter int unsigned WAYS        = 2,
    parameter int unsigned ADDR_WIDTH  = 32
) (
    input logic           clock,
    input logic           reset_n,
    l1_cache_assoc_if.slave bus
);

    localparam int unsigned SETS       = CACHE_LINES / WAYS;
    localparam int unsigned INDEX_BITS = $clog2(SETS);
    localparam int unsigned TAG_LSB    = INDEX_BITS + OFFSET_BITS;
    localparam int unsigned TAG_BITS   = ADDR_WIDTH - TAG_LSB;
    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);

    cache_state_t state, next_state;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  write_q;
    logic                  hit_q;
    logic                  hit_way_q;
    logic [SETS-1:0]       lru;
    logic [31:0]           hit_cnt;
    logic [31:0]           miss_cnt;

    logic [INDEX_BITS-1:0] index;
    logic [TAG_BITS-1:0]   tag;
    logic                  way_valid [2];
    logic [TAG_BITS-1:0]   way_tag   [2];
    logic [DATA_WIDTH-1:0] way_data  [2];
    logic [1:0]            way_hit;
    logic [1:0]            way_wr;

    logic                  lookup_hit;
    logic                  lookup_way;
    logic                  victim;
    logic                  flush_now;
    logic                  latch_en;
    logic                  fill_en;
    logic                  fill_way;
    logic [DATA_WIDTH-1:0] fill_data;
    logic                  lru_touch;
    logic                  lru_way;
    logic                  count_hit;
    logic                  count_miss;

    assign index = addr_q[TAG_LSB-1:OFFSET_BITS];
    assign tag   = addr_q[ADDR_WIDTH-1:TAG_LSB];

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        l1_cache_way #(
            .SETS       (SETS),
            .INDEX_BITS (INDEX_BITS),
            .TAG_BITS   (TAG_BITS)
        ) u_way (
            .clock    (clock),
            .reset_n  (reset_n),
            .flush    (flush_now),
            .index    (index),
            .wr_en    (way_wr[w]),
            .wr_tag   (tag),
            .wr_data  (fill_data),
            .rd_valid (way_valid[w]),
            .rd_tag   (way_tag[w]),
            .rd_data  (way_data[w])
        );
    end

    // A direct-mapped build pads the second way as permanently invalid.
    if (WAYS == 1) begin : g_pad
        assign way_valid[1] = 1'b0;
        assign way_tag[1]   = '0;
        assign way_data[1]  = '0;
    end

    assign way_hit[0]  = way_valid[0] && (way_tag[0] == tag);
    assign way_hit[1]  = way_valid[1] && (way_tag[1] == tag);
    assign lookup_hit  = |way_hit;
    assign lookup_way  = way_hit[1];
    assign way_wr[0]   = fill_en && !fill_way;
    assign way_wr[1]   = fill_en && fill_way;

    always_comb begin
        if (WAYS == 1)          victim = 1'b0;
        else if (!way_valid[0]) victim = 1'b0;
        else if (!way_valid[1]) victim = 1'b1;
        else                    victim = lru[index];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state           = state;
        bus.ready            = 1'b0;
        bus.hit              = 1'b0;
        bus.output_data      = '0;
        bus.mem_request      = 1'b0;
        bus.mem_should_write = 1'b0;
        flush_now            = 1'b0;
        latch_en             = 1'b0;
        fill_en              = 1'b0;
        fill_way             = victim;
        fill_data            = data_q;
        lru_touch            = 1'b0;
        lru_way              = victim;
        count_hit            = 1'b0;
        count_miss           = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.flush) begin
                    flush_now = 1'b1;
                end else if (bus.request) begin
                    latch_en   = 1'b1;
                    next_state = LOOKUP;
                end
            end
            LOOKUP: begin
                count_hit  = lookup_hit;
                count_miss = !lookup_hit;
                if (write_q) begin
                    next_state = WRITE_THROUGH;
                end else if (lookup_hit) begin
                    bus.ready       = 1'b1;
                    bus.hit         = 1'b1;
                    bus.output_data = way_data[lookup_way];
                    lru_touch       = 1'b1;
                    lru_way         = lookup_way;
                    next_state      = IDLE;
                end else begin
                    next_state = READ_MISS;
                end
            end
            READ_MISS: begin
                bus.mem_request = 1'b1;
                if (bus.memory_controller_ready) begin
                    fill_en         = 1'b1;
                    fill_data       = bus.memory_controller_output_data;
                    lru_touch       = 1'b1;
                    bus.ready       = 1'b1;
                    bus.output_data = bus.memory_controller_output_data;
                    next_state      = IDLE;
                end
            end
            WRITE_THROUGH: begin
                bus.mem_request      = 1'b1;
                bus.mem_should_write = 1'b1;
                fill_way             = hit_q ? hit_way_q : victim;
                lru_way              = fill_way;
                if (bus.memory_controller_ready) begin
                    fill_en    = 1'b1;
                    lru_touch  = 1'b1;
                    bus.ready  = 1'b1;
                    bus.hit    = hit_q;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            addr_q    <= '0;
            data_q    <= '0;
            write_q   <= 1'b0;
            hit_q     <= 1'b0;
            hit_way_q <= 1'b0;
        end else begin
            if (latch_en) begin
                addr_q  <= bus.address;
                data_q  <= bus.input_data;
                write_q <= bus.should_write;
            end
            if (state == LOOKUP) begin
                hit_q     <= lookup_hit;
                hit_way_q <= lookup_way;
            end
        end
    end

    // The LRU bit names the way that was not just touched.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)       lru <= '0;
        else if (flush_now) lru <= '0;
        else if (lru_touch) lru[index] <= ~lru_way;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (count_hit && (hit_cnt != '1))   hit_cnt  <= hit_cnt + 32'd1;
            if (count_miss && (miss_cnt != '1)) miss_cnt <= miss_cnt + 32'd1;
        end
    end

    assign bus.hit_count      = hit_cnt;
    assign bus.miss_count     = miss_cnt;
    assign bus.mem_address    = addr_q & WORD_MASK;
    assign bus.mem_input_data = data_q;

endmodule

// File: tb/tb_l1_cache_assoc.sv
// Self-checking bench for l1_cache_assoc (16 lines, 2 ways): directed scenarios then
// random traffic against a recency-list cache model and a backing-memory map.
module tb_l1_cache_assoc;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    l1_cache_assoc_if #(.ADDR_WIDTH(32)) bus ();

    l1_cache_assoc #(
        .CACHE_LINES (16),
        .WAYS        (2),
        .ADDR_WIDTH  (32)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Model: per set, word addresses ordered most-recent first; memory as a sparse map.
    logic [31:0] rec [8][2];
    int unsigned rec_n [8];
    logic [31:0] backing [logic [31:0]];
    int unsigned exp_hits   = 0;
    int unsigned exp_misses = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic get_mem(input logic [31:0] wa, output logic [31:0] val);
        if (!backing.exists(wa)) backing[wa] = $urandom;
        val = backing[wa];
    endtask

    task automatic model_clear();
        for (int s = 0; s < 8; s++) rec_n[s] = 0;
    endtask

    task automatic model_access(input logic [31:0] addr, output bit is_hit);
        logic [31:0] wa;
        int unsigned s;
        int k;
        wa = addr & 32'hFFFF_FFFC;
        s  = (wa >> 2) % 8;
        k  = -1;
        for (int j = 0; j < int'(rec_n[s]); j++) if (rec[s][j] == wa) k = j;
        is_hit = (k >= 0);
        if (is_hit) begin
            exp_hits++;
        end else begin
            exp_misses++;
            if (rec_n[s] < 2) rec_n[s]++;
            k = int'(rec_n[s]) - 1;
        end
        for (int j = k; j > 0; j--) rec[s][j] = rec[s][j-1];
        rec[s][0] = wa;
    endtask

    // Called just after a rising edge; returns just after the completing edge.
    task automatic access(input logic [31:0] addr, input bit wr, input logic [31:0] wdata,
                          input int unsigned delay, input string tag);
        bit          exp_hit, got, saw_mem, memwr_seen;
        logic [31:0] wa, exp_data, mem_addr_seen, mem_wdata_seen, got_data;
        logic        got_hit;
        int unsigned lat, waitc;
        wa = addr & 32'hFFFF_FFFC;
        got = 0; saw_mem = 0; memwr_seen = 0; lat = 0; waitc = 0;
        mem_addr_seen = '0; mem_wdata_seen = '0; got_data = '0; got_hit = 1'b0;
        get_mem(wa, exp_data);
        model_access(addr, exp_hit);
        bus.request = 1'b1; bus.address = addr; bus.should_write = wr; bus.input_data = wdata;
        while (!got && lat < 100) begin
            @(negedge clock);
            if (bus.mem_request) begin
                saw_mem = 1; mem_addr_seen = bus.mem_address;
                memwr_seen = bus.mem_should_write; mem_wdata_seen = bus.mem_input_data;
            end
            if (bus.ready) begin
                got = 1; got_hit = bus.hit; got_data = bus.output_data; bus.request = 1'b0;
            end
            @(posedge clock); #1;
            lat++;
            bus.memory_controller_ready = 1'b0;
            if (!got && bus.mem_request) begin
                waitc++;
                if (waitc >= delay) begin
                    bus.memory_controller_ready = 1'b1;
                    bus.memory_controller_output_data = wr ? (32'hBAD0_0000 ^ wa) : exp_data;
                end
            end
        end
        bus.request = 1'b0;
        if (wr) backing[wa] = wdata;
        check({tag, ".done"}, 32'(got), 32'd1);
        if (got) begin
            check({tag, ".hit"}, 32'(got_hit), 32'(exp_hit));
            check({tag, ".mem_req"}, 32'(saw_mem), 32'(wr || !exp_hit));
            if (saw_mem) begin
                check({tag, ".mem_addr"}, mem_addr_seen, wa);
                check({tag, ".mem_wr"}, 32'(memwr_seen), 32'(wr));
                if (wr) check({tag, ".mem_wdata"}, mem_wdata_seen, wdata);
            end
            if (!wr) check({tag, ".data"}, got_data, exp_data);
            if (!wr && exp_hit) check({tag, ".latency"}, lat, 32'd2);
            check({tag, ".hit_count"}, bus.hit_count, exp_hits);
            check({tag, ".miss_count"}, bus.miss_count, exp_misses);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          seen_ready, seen_mem;
        int unsigned hc0, mc0;

        bus.request = 1'b0; bus.address = '0; bus.input_data = '0; bus.should_write = 1'b0;
        bus.flush = 1'b0; bus.memory_controller_ready = 1'b0; bus.memory_controller_output_data = '0;
        model_clear();

        #1;
        check("rst.ready", 32'(bus.ready), 32'd0);
        check("rst.hit", 32'(bus.hit), 32'd0);
        check("rst.mem_request", 32'(bus.mem_request), 32'd0);
        check("rst.mem_should_write", 32'(bus.mem_should_write), 32'd0);
        check("rst.output_data", bus.output_data, 32'd0);
        check("rst.hit_count", bus.hit_count, 32'd0);
        check("rst.miss_count", bus.miss_count, 32'd0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;

        // Cold read then re-read of 0x100.
        backing[32'h100] = 32'hDEAD_BEEF;
        access(32'h100, 1'b0, '0, 3, "cold_read");
        access(32'h100, 1'b0, '0, 3, "reread");

        // Set-0 conflict: 0x300 evicts the LRU line 0x200.
        access(32'h200, 1'b0, '0, 2, "fill_200");
        access(32'h100, 1'b0, '0, 2, "touch_100");
        access(32'h300, 1'b0, '0, 1, "fill_300");
        access(32'h100, 1'b0, '0, 1, "keep_100");
        access(32'h200, 1'b0, '0, 2, "evicted_200");

        // Write-through with allocation.
        access(32'h40, 1'b1, 32'h1234_5678, 2, "write_40");
        access(32'h40, 1'b0, '0, 2, "read_40");

        // Flush wins over a simultaneous request.
        hc0 = bus.hit_count; mc0 = bus.miss_count;
        bus.flush = 1'b1; bus.request = 1'b1; bus.address = 32'h100; bus.should_write = 1'b0;
        @(posedge clock); #1;
        bus.flush = 1'b0; bus.request = 1'b0;
        seen_ready = 0; seen_mem = 0;
        repeat (3) begin
            @(negedge clock);
            if (bus.ready) seen_ready = 1;
            if (bus.mem_request) seen_mem = 1;
        end
        check("flush.no_ready", 32'(seen_ready), 32'd0);
        check("flush.no_mem", 32'(seen_mem), 32'd0);
        check("flush.hit_count", bus.hit_count, hc0);
        check("flush.miss_count", bus.miss_count, mc0);
        model_clear();
        @(posedge clock); #1;
        access(32'h100, 1'b0, '0, 1, "post_flush");

        // Reset while a read miss waits on the controller.
        bus.request = 1'b1; bus.address = 32'h500; bus.should_write = 1'b0;
        seen_mem = 0;
        for (int i = 0; i < 20 && !seen_mem; i++) begin
            @(negedge clock);
            if (bus.mem_request) seen_mem = 1;
        end
        check("abort.mem_seen", 32'(seen_mem), 32'd1);
        reset_n = 1'b0;
        bus.request = 1'b0;
        #1;
        check("abort.mem_request", 32'(bus.mem_request), 32'd0);
        check("abort.ready", 32'(bus.ready), 32'd0);
        check("abort.hit_count", bus.hit_count, 32'd0);
        check("abort.miss_count", bus.miss_count, 32'd0);
        model_clear();
        exp_hits = 0; exp_misses = 0;
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;
        access(32'h100, 1'b0, '0, 2, "post_reset");
        access(32'h500, 1'b0, '0, 2, "post_reset_500");

        // Random traffic over two sets and four tags each.
        for (int n = 0; n < 80; n++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 3) << 5) | ($urandom_range(0, 1) << 2) | $urandom_range(0, 3);
            access(a, ($urandom_range(0, 2) == 0), $urandom, $urandom_range(1, 4), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
